// File: rtl/layer0.sv
// layer0: 3x3 zero-padded convolution over a 64x64 image with bias, rounding and ReLU.
// Define LAYER0_SAT_EN to clamp large results to 19'h7FFFF instead of wrapping.
module layer0 #(
    parameter int unsigned IMG_W  = 64,
    parameter logic [179:0] KERNEL = {20'hFAC19, 20'hFC834, 20'hFA6D7, 20'hF6E54, 20'hF8F71,
                                      20'h01004, 20'h06D43, 20'h092D5, 20'h0A89E},
    parameter logic [19:0]  BIAS   = 20'h01310,
    localparam int unsigned CW     = $clog2(IMG_W),
    localparam int unsigned AW     = 2 * CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_iaddr,
    input  logic [19:0]   i_idata,
    output logic          o_valid,
    output logic [18:0]   o_data,
    input  logic          i_busy
);

    localparam int unsigned DW   = 20;
    localparam int unsigned RW   = 19;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned ACCW = 44;
    localparam int unsigned FRAC = 16;
    localparam int unsigned TW   = ACCW - FRAC;
    localparam int unsigned NTAP = 9;

    localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
    localparam logic signed [ACCW-1:0] C_RND =
        (ACCW'($signed(BIAS)) <<< FRAC) + (ACCW'(1) <<< (FRAC - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_ROUND,
        S_OUT,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic [1:0]              r_tr;
    logic [1:0]              r_tc;
    logic [3:0]              r_tap;
    logic [3:0]              r_prev_tap;
    logic                    r_prev_pad;
    logic                    r_acc_en;
    logic signed [ACCW-1:0]  r_acc;

    logic                    w_pad;
    logic [1:0]              w_tr_nxt;
    logic [1:0]              w_tc_nxt;
    logic                    w_last_pix;
    logic [CW-1:0]           w_row_nxt;
    logic [CW-1:0]           w_col_nxt;
    logic signed [DW-1:0]    w_k;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_term;
    logic signed [ACCW-1:0]  w_sum;
    logic signed [TW-1:0]    w_t;
    logic [RW-1:0]           w_res;
    logic                    w_unused;

    // Tap offsets r_tr/r_tc are stored biased by +1 (0..2 means -1..+1).
    function automatic logic [AW-1:0] f_addr(input logic [CW-1:0] row, input logic [CW-1:0] col,
                                             input logic [1:0] tr, input logic [1:0] tc);
        logic [CW-1:0] ar;
        logic [CW-1:0] ac;
        ar = row + CW'(tr) - CW'(1);
        ac = col + CW'(tc) - CW'(1);
        return {ar, ac};
    endfunction

    assign w_pad = ((r_tr == 2'd0) && (r_row == '0))   ||
                   ((r_tr == 2'd2) && (r_row == C_MAX)) ||
                   ((r_tc == 2'd0) && (r_col == '0))   ||
                   ((r_tc == 2'd2) && (r_col == C_MAX));

    assign w_tc_nxt   = (r_tc == 2'd2) ? 2'd0 : r_tc + 2'd1;
    assign w_tr_nxt   = (r_tc == 2'd2) ? r_tr + 2'd1 : r_tr;
    assign w_last_pix = (r_row == C_MAX) && (r_col == C_MAX);
    assign w_col_nxt  = r_col + CW'(1);
    assign w_row_nxt  = (r_col == C_MAX) ? r_row + CW'(1) : r_row;

    // Weight of the tap whose pixel arrives this cycle.
    always_comb begin
        w_k = '0;
        for (int k = 0; k < NTAP; k++) begin
            if (r_prev_tap == 4'(k)) begin
                w_k = KERNEL[DW*k +: DW];
            end
        end
    end

    assign w_prod = $signed(i_idata) * w_k;
    assign w_term = r_prev_pad ? '0 : w_prod;

    assign w_sum = r_acc + C_RND;
    assign w_t   = w_sum[ACCW-1:FRAC];

    // ReLU, then clamp or wrap into the 19-bit result.
    always_comb begin
        w_res = '0;
        if (!w_t[TW-1]) begin
`ifdef LAYER0_SAT_EN
            if (|w_t[TW-2:RW]) begin
                w_res = '1;
            end else begin
                w_res = w_t[RW-1:0];
            end
`else
            w_res = w_t[RW-1:0];
`endif
        end
    end

    assign w_unused = ^{w_sum[FRAC-1:0], w_t};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_tr       <= '0;
            r_tc       <= '0;
            r_tap      <= '0;
            r_prev_tap <= '0;
            r_prev_pad <= 1'b0;
            r_acc_en   <= 1'b0;
            r_acc      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_iaddr    <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
        end else begin
            o_done   <= 1'b0;
            r_acc_en <= (r_state == S_FETCH);
            if (r_acc_en) begin
                r_acc <= r_acc + ACCW'(w_term);
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_FETCH;
                        o_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_tr    <= '0;
                        r_tc    <= '0;
                        r_tap   <= '0;
                        r_acc   <= '0;
                        o_iaddr <= f_addr('0, '0, 2'd0, 2'd0);
                    end
                end

                // Issue one tap address per cycle; its data is accumulated next cycle.
                S_FETCH: begin
                    r_prev_tap <= r_tap;
                    r_prev_pad <= w_pad;
                    if (r_tap == 4'd8) begin
                        r_state <= S_LAST;
                    end else begin
                        r_tap   <= r_tap + 4'd1;
                        r_tr    <= w_tr_nxt;
                        r_tc    <= w_tc_nxt;
                        o_iaddr <= f_addr(r_row, r_col, w_tr_nxt, w_tc_nxt);
                    end
                end

                S_LAST: begin
                    r_state <= S_ROUND;
                end

                S_ROUND: begin
                    o_data  <= w_res;
                    o_valid <= 1'b1;
                    r_state <= S_OUT;
                end

                S_OUT: begin
                    if (!i_busy) begin
                        o_valid <= 1'b0;
                        if (w_last_pix) begin
                            r_state <= S_DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_row   <= w_row_nxt;
                            r_col   <= w_col_nxt;
                            r_tr    <= '0;
                            r_tc    <= '0;
                            r_tap   <= '0;
                            r_acc   <= '0;
                            o_iaddr <= f_addr(w_row_nxt, w_col_nxt, 2'd0, 2'd0);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer0.sv
// Directed self-checking bench for layer0: frame runs, padding, stall, abort and overflow.
module tb_layer0;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_iaddr;
    logic [19:0] i_idata;
    logic        o_valid;
    logic [18:0] o_data;
    logic        i_busy;

    logic [19:0] mem [4096];
    logic [11:0] r_addr_q;

    int checks = 0;
    int errors = 0;

    // Weights of taps 0..8 as plain integers (4.16 signed).
    int kern [9] = '{43166, 37589, 27971, 4100, -28815, -37292, -22825, -14284, -21479};

`ifdef LAYER0_SAT_EN
    localparam logic [18:0] OVF_EXP = 19'h7FFFF;
`else
    localparam logic [18:0] OVF_EXP = 19'h51196;
`endif

    layer0 dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_iaddr (o_iaddr),
        .i_idata (i_idata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_busy  (i_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: data appears the cycle after the address.
    always @(posedge clk) r_addr_q <= o_iaddr;
    assign i_idata = mem[r_addr_q];

    function automatic logic [18:0] ref_pix(input int r, input int c);
        longint acc = 0;
        longint t;
        logic signed [19:0] pv;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64) begin
                    pv  = mem[(r + dr) * 64 + (c + dc)];
                    acc = acc + longint'(pv) * longint'(kern[(dr + 1) * 3 + (dc + 1)]);
                end
            end
        end
        t = (acc + (longint'(4880) <<< 16) + longint'(32768)) >>> 16;
        if (t < 0) return 19'h0;
`ifdef LAYER0_SAT_EN
        if (t > 524287) return 19'h7FFFF;
`endif
        return 19'(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_valid !== 1'b1 && n < 64);
        if (o_valid !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL %s: timeout waiting for o_valid", tag);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1);
        end
    endtask

    task automatic check_quiet(input string tag);
        logic seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_valid !== 1'b0) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [11:0] saved;
        int r;
        int c;

        reset   = 1'b1;
        i_start = 1'b0;
        i_busy  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 20'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_iaddr", 32'(o_iaddr), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Start coinciding with reset is dropped.
        i_start = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        chk("start_vs_reset", 32'(o_busy), 32'd0);
        reset   = 1'b0;
        i_start = 1'b0;
        @(negedge clk);

        // Frame A: all ones, last row/column unknown so padded taps must be ignored.
        for (int i = 0; i < 4096; i++)
            mem[i] = ((i / 64) == 63 || (i % 64) == 63) ? 20'hxxxxx : 20'h10000;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_rise", 32'(o_busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("addr_tap4", 32'(o_iaddr), 32'd0);
        @(negedge clk);
        chk("addr_tap5", 32'(o_iaddr), 32'd1);
        repeat (2) @(negedge clk);
        chk("addr_tap7", 32'(o_iaddr), 32'd64);
        @(negedge clk);
        chk("addr_tap8", 32'(o_iaddr), 32'd65);
        repeat (2) @(negedge clk);
        chk("valid_cycle10", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("valid_cycle11", 32'(o_valid), 32'd1);
        chk("A_corner00", 32'(o_data), 32'd0);
        for (int p = 1; p < 128; p++) begin
            wait_valid("A_wait");
            if ((p % 64) <= 61) chk($sformatf("A_pix(%0d,%0d)", p / 64, p % 64), 32'(o_data), 32'd0);
        end
        repeat (5) @(negedge clk);
        chk("A_busy_mid", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("A_abort", {o_busy, o_done, o_valid, o_iaddr, o_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_quiet("A_no_done");

        // Frame C: single pixel at (0,1); stall on third result, then reset mid-stall.
        for (int i = 0; i < 4096; i++) mem[i] = 20'h0;
        mem[1] = 20'h10000;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_valid("C_wait");
        chk("C_pix(0,0)", 32'(o_data), 32'd0);
        wait_valid("C_wait");
        chk("C_pix(0,1)", 32'(o_data), 32'd0);
        @(negedge clk);
        chk("C_valid_drop", 32'(o_valid), 32'd0);
        i_busy = 1'b1;
        wait_valid("C_wait");
        chk("C_pix(0,2)", 32'(o_data), 32'h2314);
        saved = o_iaddr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("C_stall_hold", {o_valid, o_data, o_iaddr}, {1'b1, 19'h02314, saved});
        end
        i_busy = 1'b0;
        @(negedge clk);
        chk("C_release", 32'(o_valid), 32'd0);
        for (int p = 3; p < 66; p++) begin
            r = p / 64;
            c = p % 64;
            wait_valid("C_wait");
            chk($sformatf("C_pix(%0d,%0d)", r, c), 32'(o_data), 32'(ref_pix(r, c)));
            if (p == 3)  chk("C_hand(0,3)", 32'(o_data), 32'h01310);
            if (p == 64) chk("C_hand(1,0)", 32'(o_data), 32'h08053);
            if (p == 65) chk("C_hand(1,1)", 32'(o_data), 32'h0A5E5);
        end
        @(negedge clk);
        i_busy = 1'b1;
        wait_valid("C_wait");
        repeat (3) @(negedge clk);
        chk("C_stall2_valid", 32'(o_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("C_stall_reset", {o_busy, o_done, o_valid, o_iaddr, o_data}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        i_busy = 1'b0;
        check_quiet("C_no_done");

        // Frame B: full frame with edges, a delta and an overflow neighbourhood.
        for (int i = 0; i < 4096; i++) begin
            r = i / 64;
            mem[i] = (r == 0 || r == 62 || r == 63) ? 20'h10000 : 20'h0;
        end
        mem[10 * 64 + 10] = 20'h10000;
        mem[4 * 64 + 4] = 20'h7FFFF;
        mem[4 * 64 + 5] = 20'h7FFFF;
        mem[4 * 64 + 6] = 20'h7FFFF;
        mem[5 * 64 + 4] = 20'h7FFFF;
        mem[5 * 64 + 5] = 20'h80000;
        mem[5 * 64 + 6] = 20'h80000;
        mem[6 * 64 + 4] = 20'h80000;
        mem[6 * 64 + 5] = 20'h80000;
        mem[6 * 64 + 6] = 20'h80000;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int p = 0; p < 4096; p++) begin
            r = p / 64;
            c = p % 64;
            wait_valid("B_wait");
            chk($sformatf("B_pix(%0d,%0d)", r, c), 32'(o_data), 32'(ref_pix(r, c)));
            if (p == 0)             chk("B_hand(0,0)",   32'(o_data), 32'h0);
            if (p == 64)            chk("B_hand(1,0)",   32'(o_data), 32'h11328);
            if (p == 65)            chk("B_hand(1,1)",   32'(o_data), 32'h1BBC6);
            if (p == 5 * 64 + 5)    chk("B_overflow",    32'(o_data), 32'(OVF_EXP));
            if (p == 9 * 64 + 9)    chk("B_hand(9,9)",   32'(o_data), 32'h0);
            if (p == 11 * 64 + 11)  chk("B_hand(11,11)", 32'(o_data), 32'h0BBAE);
            if (p == 20 * 64 + 20)  chk("B_hand(20,20)", 32'(o_data), 32'h01310);
            if (p == 62 * 64 + 63)  chk("B_hand(62,63)", 32'(o_data), 32'h0);
            if (p == 63 * 64 + 5)   chk("B_hand(63,5)",  32'(o_data), 32'h0C98F);
            if (p == 63 * 64 + 63)  chk("B_hand(63,63)", 32'(o_data), 32'h0EDF8);
        end
        @(negedge clk);
        chk("B_done_pulse", 32'(o_done), 32'd1);
        chk("B_busy_low",   32'(o_busy), 32'd0);
        i_start = 1'b1;
        @(negedge clk);
        chk("B_done_once",     32'(o_done), 32'd0);
        chk("B_start_in_done", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("B_restart", 32'(o_busy), 32'd1);
        i_start = 1'b0;
        reset   = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
